lm_sm_sequencer: RTL and testbench

Multi-cycle controller for the LM (load multiple) and SM (store multiple) instructions of the IITB-RISC-23 core. The decode stage hands it a base address and an 8-bit register list. It then walks the list one register per data-memory transaction, driving the data-memory port and the register-file read/write ports. While it works, it holds `busy` high so the pipeline stalls fetch and decode.

---
 rtl/lm_sm_sequencer_if.sv | 25 ++
 rtl/lm_sm_sequencer.sv | 102 ++++++++++
 tb/tb_lm_sm_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lm_sm_sequencer_if.sv
// Data-memory and register-file port bundle driven by the LM/SM sequencer.
// The master side is the sequencer; the slave side is the memory/register-file glue.
interface lm_sm_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  rf_rd_idx;
  logic [15:0] rf_rd_data;
  logic        rf_we;
  logic [2:0]  rf_wr_idx;
  logic [15:0] rf_wdata;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata, rf_rd_idx, rf_we, rf_wr_idx, rf_wdata,
    input  mem_rdata, mem_ready, rf_rd_data
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata, rf_rd_idx, rf_we, rf_wr_idx, rf_wdata,
    output mem_rdata, mem_ready, rf_rd_data
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-cycle sequencer: walks an 8-bit register list, one data-memory
// transaction per selected register, stalling the front end while busy.
module lm_sm_sequencer #(
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    is_store_i,
  input  logic [15:0]             base_addr_i,
  input  logic [7:0]              reg_list_i,
  output logic                    busy_o,
  output logic                    done_o,
  lm_sm_sequencer_if.master       bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [7:0]  pend_q;
  logic [7:0]  pend_d;
  logic [15:0] addr_q;
  logic [15:0] addr_d;
  logic        st_q;

  logic [2:0]  hiBit;
  logic [7:0]  hiMask;
  logic [2:0]  curIdx;
  logic        active;
  logic        lastXfer;

  // List bit 7 is R0, so the highest pending bit is the lowest register number.
  always_comb begin
    hiBit = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (pend_q[b]) begin
        hiBit = 3'(b);
      end
    end
  end

  assign hiMask   = 8'b0000_0001 << hiBit;
  assign curIdx   = ~hiBit;
  assign active   = (state_q == S_ACCESS);
  assign pend_d   = pend_q & ~hiMask;
  assign addr_d   = addr_q + 16'(ADDR_STEP);
  assign lastXfer = (pend_d == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 8'h00;
      addr_q  <= 16'h0000;
      st_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            pend_q  <= reg_list_i;
            addr_q  <= base_addr_i;
            st_q    <= is_store_i;
            state_q <= (reg_list_i != 8'h00) ? S_ACCESS : S_DONE;
          end
        end
        S_ACCESS: begin
          if (bus.mem_ready) begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            if (lastXfer) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

  // Strobes are gated by rst so nothing is written in a reset cycle.
  assign bus.mem_addr  = active ? addr_q : 16'h0000;
  assign bus.mem_rd    = active && !st_q && !rst;
  assign bus.mem_wr    = active &&  st_q && !rst;
  assign bus.mem_wdata = bus.rf_rd_data;

  assign bus.rf_rd_idx = active ? curIdx : 3'd0;
  assign bus.rf_wr_idx = active ? curIdx : 3'd0;
  assign bus.rf_we     = active && !st_q && bus.mem_ready && !rst;
  assign bus.rf_wdata  = bus.mem_rdata;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: a list-walking reference model fills
// an expectation queue, and a negedge monitor pops it on each DUT transfer/done.
module tb_lm_sm_sequencer;

  localparam int unsigned STEP = 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic        isStore;
  logic [15:0] baseAddr;
  logic [7:0]  regList;
  logic        busy;
  logic        done;
  logic [15:0] regVals [8];

  lm_sm_sequencer_if bus ();

  lm_sm_sequencer #(.ADDR_STEP(STEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .is_store_i  (isStore),
    .base_addr_i (baseAddr),
    .reg_list_i  (regList),
    .busy_o      (busy),
    .done_o      (done),
    .bus         (bus)
  );

  typedef struct {
    bit          isDone;
    bit          isStore;
    logic [15:0] addr;
    logic [2:0]  idx;
    logic [15:0] data;
    int          cyc;
  } item_t;

  item_t expQ[$];

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;
  int curStart   = -100;
  int curDone    = 0;
  bit monOn      = 0;
  bit skipBusy   = 0;

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic bit readyBit(input logic [31:0] p, input int c);
    return (c < 32) ? p[c] : 1'b1;
  endfunction

  // Memory and register file respond combinationally to the addressed location.
  assign bus.mem_rdata  = memFn(bus.mem_addr);
  assign bus.rf_rd_data = regVals[bus.rf_rd_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, required, $time);
  endtask

  task automatic reportFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: actual=event required=none (t=%0t)", name, $time);
  endtask

  // Builds the expected transfer sequence from the list and ready pattern, then drives it.
  task automatic applyStimulus(input logic st, input logic [15:0] base, input logic [7:0] list,
                               input logic [31:0] readyPat, input bit noise);
    int    regsQ[$];
    int    k;
    int    c;
    int    doneCyc;
    item_t it;
    for (int r = 0; r < 8; r++) if (list[7 - r]) regsQ.push_back(r);
    k = 0;
    c = 1;
    while (k < regsQ.size()) begin
      if (readyBit(readyPat, c)) begin
        it.isDone  = 0;
        it.isStore = st;
        it.addr    = 16'(int'(base) + k * int'(STEP));
        it.idx     = 3'(regsQ[k]);
        it.data    = st ? regVals[regsQ[k]] : memFn(it.addr);
        it.cyc     = c;
        expQ.push_back(it);
        k++;
      end
      c++;
    end
    doneCyc   = c;
    it        = '{isDone: 1, isStore: st, addr: 16'h0, idx: 3'd0, data: 16'h0, cyc: doneCyc};
    expQ.push_back(it);

    @(negedge clk);
    start    = 1'b1;
    isStore  = st;
    baseAddr = base;
    regList  = list;
    curStart = cycle;
    curDone  = doneCyc;
    @(posedge clk);
    #1;
    for (int cc = 1; cc <= doneCyc; cc++) begin
      bus.mem_ready = readyBit(readyPat, cc);
      if (noise && $urandom_range(0, 2) == 0) begin
        start    = 1'b1;
        isStore  = 1'($urandom);
        baseAddr = 16'($urandom);
        regList  = 8'($urandom) | 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start         = 1'b0;
    bus.mem_ready = 1'b0;
    checkOutput("queue_drained", expQ.size(), 0);
    expQ.delete();
  endtask

  // Aborts a full-list LM in its second access cycle and confirms nothing leaks out.
  task automatic resetMidAccess();
    item_t it;
    skipBusy = 1;
    for (int i = 0; i < 8; i++) regVals[i] = 16'(32'hAA00 + i);
    it = '{isDone: 0, isStore: 0, addr: 16'h0200, idx: 3'd0, data: memFn(16'h0200), cyc: 1};
    expQ.push_back(it);
    @(negedge clk);
    start    = 1'b1;
    isStore  = 1'b0;
    baseAddr = 16'h0200;
    regList  = 8'hFF;
    curStart = cycle;
    curDone  = 1000;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    regList       = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    checkOutput("rst_cycle_rf_we", bus.rf_we, 0);
    checkOutput("rst_cycle_mem_rd", bus.mem_rd, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_done", done, 0);
    checkOutput("post_rst_mem_rd", bus.mem_rd, 0);
    checkOutput("post_rst_mem_addr", bus.mem_addr, 0);
    checkOutput("post_rst_queue", expQ.size(), 0);
    expQ.delete();
    curStart = cycle;
    curDone  = 0;
    skipBusy = 0;
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: checks busy every cycle and pops the scoreboard on transfers and done pulses.
  always @(negedge clk) begin
    int    rel;
    item_t e;
    if (monOn && !rst) begin
      rel = cycle - curStart;
      if (!skipBusy) checkOutput("busy", busy, 32'(rel >= 1 && rel <= curDone));
      checkOutput("rf_we_gate", bus.rf_we, bus.mem_rd & bus.mem_ready);
      if ((bus.mem_rd || bus.mem_wr) && bus.mem_ready) begin
        if (expQ.size() == 0) reportFail("unexpected_xfer");
        else begin
          e = expQ.pop_front();
          checkOutput("xfer_not_done_item", 32'(e.isDone), 0);
          checkOutput("xfer_cycle", rel, e.cyc);
          checkOutput("xfer_dir", bus.mem_wr, e.isStore);
          checkOutput("xfer_addr", bus.mem_addr, e.addr);
          checkOutput("xfer_rd_idx", bus.rf_rd_idx, e.idx);
          if (e.isStore) begin
            checkOutput("sm_wdata", bus.mem_wdata, e.data);
          end else begin
            checkOutput("lm_we", bus.rf_we, 1);
            checkOutput("lm_wr_idx", bus.rf_wr_idx, e.idx);
            checkOutput("lm_wdata", bus.rf_wdata, e.data);
          end
        end
      end else if (bus.mem_rd || bus.mem_wr) begin
        if (expQ.size() == 0) reportFail("unexpected_request");
        else begin
          checkOutput("stall_addr", bus.mem_addr, expQ[0].addr);
          checkOutput("stall_idx", bus.rf_rd_idx, expQ[0].idx);
          checkOutput("stall_dir", bus.mem_wr, expQ[0].isStore);
        end
      end
      if (done) begin
        if (expQ.size() == 0) reportFail("unexpected_done");
        else begin
          e = expQ.pop_front();
          checkOutput("done_item", 32'(e.isDone), 1);
          checkOutput("done_cycle", rel, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [31:0] pat;
    logic [15:0] base;
    logic [7:0]  list;
    rst           = 1'b1;
    start         = 1'b0;
    isStore       = 1'b0;
    baseAddr      = 16'h0000;
    regList       = 8'h00;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) regVals[i] = 16'h0000;

    repeat (2) @(posedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_rf_we_forced", bus.rf_we, 0);
    checkOutput("rst_mem_rd_forced", bus.mem_rd, 0);
    checkOutput("rst_mem_wr_forced", bus.mem_wr, 0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_mem_addr", bus.mem_addr, 0);
    checkOutput("reset_rd_idx", bus.rf_rd_idx, 0);
    checkOutput("reset_wr_idx", bus.rf_wr_idx, 0);
    monOn = 1;

    $display("[TB] directed: LM 0xA1 at 0x0040");
    applyStimulus(1'b0, 16'h0040, 8'hA1, 32'hFFFF_FFFF, 1'b0);
    $display("[TB] directed: SM 0xFF at 0x0100");
    for (int i = 0; i < 8; i++) regVals[i] = 16'(32'h1110 + i);
    applyStimulus(1'b1, 16'h0100, 8'hFF, 32'hFFFF_FFFF, 1'b0);
    $display("[TB] directed: LM R3 with three wait cycles");
    applyStimulus(1'b0, 16'h0333, 8'h10, ~32'h0000_000E, 1'b0);
    $display("[TB] directed: empty list");
    applyStimulus(1'b0, 16'h1234, 8'h00, 32'hFFFF_FFFF, 1'b1);
    $display("[TB] directed: SM address wrap");
    applyStimulus(1'b1, 16'hFFFE, 8'hE0, 32'hFFFF_FFFF, 1'b0);
    $display("[TB] directed: reset mid-access");
    resetMidAccess();

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) regVals[i] = 16'($urandom);
      pat  = $urandom | $urandom;
      base = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      list = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(1'($urandom), base, list, pat, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
